// File: rtl/roll_left_seq.sv
// Sequential 16-bit left rotator: a latched amount is applied as four binary stages (8/4/2/1),
// with an optional bit-reversal of the final word. It uses a valid/ready handshake on both sides.
module roll_left_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] inData,
    input  logic [3:0]  amt,
    input  logic        rev_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] outData,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] work_r;
    logic [1:0]  cnt_r;
    logic [3:0]  amt_r;
    logic        rev_r;
    logic [15:0] outdata_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;
    logic        in_ready_nx_s;
    logic        out_valid_nx_s;
    logic        busy_nx_s;
    logic [15:0] stage_word_s;
    logic [15:0] final_word_s;

    // Stage k rotates by 8>>k when amount bit (3-k) is set; rotations always wrap.
    function automatic logic [15:0] rot_stage(input logic [15:0] w, input logic [1:0] stage,
                                              input logic [3:0] a);
        logic [15:0] r;
        r = w;
        case (stage)
            2'd0:    if (a[3]) r = {w[7:0],  w[15:8]};  else r = w;
            2'd1:    if (a[2]) r = {w[11:0], w[15:12]}; else r = w;
            2'd2:    if (a[1]) r = {w[13:0], w[15:14]}; else r = w;
            2'd3:    if (a[0]) r = {w[14:0], w[15]};    else r = w;
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            r[i] = w[15-i];
        end
        return r;
    endfunction

    // Current stage result and the final word as it would be loaded into outData.
    always_comb begin
        stage_word_s = rot_stage(work_r, cnt_r, amt_r);
        if (rev_r) begin
            final_word_s = bitrev16(stage_word_s);
        end else begin
            final_word_s = stage_word_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; leaving DONE never accepts on the same edge because acceptance is IDLE-only.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)       state_nx_s = SHIFT; else state_nx_s = IDLE;
            SHIFT:   if (cnt_r == 2'd3)  state_nx_s = DONE;  else state_nx_s = SHIFT;
            DONE:    if (out_ready)      state_nx_s = IDLE;  else state_nx_s = DONE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode from the next state, so the flag flops line up with state_r.
    always_comb begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        busy_nx_s      = 1'b1;
        case (state_nx_s)
            IDLE:    begin in_ready_nx_s = 1'b1; busy_nx_s = 1'b0; end
            SHIFT:   begin in_ready_nx_s = 1'b0; out_valid_nx_s = 1'b0; end
            DONE:    begin out_valid_nx_s = 1'b1; end
            default: begin in_ready_nx_s = 1'b1; busy_nx_s = 1'b0; end
        endcase
    end

    // Registered handshake and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    // Datapath: latch on accept, one stage per SHIFT edge, and load the result on stage 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r    <= 16'h0000;
            cnt_r     <= 2'd0;
            amt_r     <= 4'd0;
            rev_r     <= 1'b0;
            outdata_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r <= inData;
                        amt_r  <= amt;
                        rev_r  <= rev_en;
                        cnt_r  <= 2'd0;
                    end
                end
                SHIFT: begin
                    work_r <= stage_word_s;
                    cnt_r  <= cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        outdata_r <= final_word_s;
                    end
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign outData   = outdata_r;

endmodule
